// File: rtl/lsu_pkg.sv
// Shared types and func3 decoding for the load/store sequencer.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DATA = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_NONE = 2'b11
    } lsu_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Unsigned variants exist only for loads; everything else outside the table is illegal.
    function automatic logic f3_illegal(input logic we, input logic [2:0] func3);
        logic bad;
        bad = 1'b0;
        case (func3)
            F3_LB, F3_LH, F3_LW: bad = 1'b0;
            F3_LBU, F3_LHU:      bad = we;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane mask, store-data positioning and load-data extraction.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    output logic [3:0]  lo_mask,
    output logic [3:0]  hi_mask,
    output logic [31:0] lo_wdata,
    output logic [31:0] hi_wdata,
    output logic        split,
    output logic        illegal,
    output logic [31:0] load_data
);

    lsu_size_e   size_s;
    logic [3:0]  base_s;
    logic [7:0]  mask8_s;
    logic [63:0] wide_s;
    logic [63:0] merged_s;
    logic        sext_s;

    assign size_s  = lsu_size_e'(func3[1:0]);
    assign illegal = f3_illegal(we, func3);
    assign sext_s  = ~func3[2];

    // Byte-enable pattern for the access size; suppressed for illegal requests.
    always_comb begin
        base_s = 4'b0000;
        case (size_s)
            SZ_BYTE: base_s = 4'b0001;
            SZ_HALF: base_s = 4'b0011;
            SZ_WORD: base_s = 4'b1111;
            default: base_s = 4'b0000;
        endcase
        if (illegal) begin
            base_s = 4'b0000;
        end else begin
            base_s = base_s;
        end
    end

    assign mask8_s  = {4'b0000, base_s} << addr_lo;
    assign lo_mask  = mask8_s[3:0];
    assign hi_mask  = mask8_s[7:4];
    assign split    = |mask8_s[7:4];

    assign wide_s   = {32'h0000_0000, wdata} << {addr_lo, 3'b000};
    assign lo_wdata = wide_s[31:0];
    assign hi_wdata = wide_s[63:32];

    assign merged_s = {hi_word, lo_word} >> {addr_lo, 3'b000};

    // Keep the addressed bytes and extend to 32 bits.
    always_comb begin
        load_data = 32'h0000_0000;
        case (size_s)
            SZ_BYTE: load_data = {{24{sext_s & merged_s[7]}}, merged_s[7:0]};
            SZ_HALF: load_data = {{16{sext_s & merged_s[15]}}, merged_s[15:0]};
            SZ_WORD: load_data = merged_s[31:0];
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer FSM: splits misaligned accesses into two word cycles
// and returns one registered response per request.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_AW = 9
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_func3,
    input  logic [15:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_rsp_valid,
    output logic              o_rsp_err,
    output logic [31:0]       o_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [3:0]        o_mem_bmask,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    lsu_state_e        state_r, state_s;
    logic              we_r;
    logic [2:0]        func3_r;
    logic [1:0]        offs_r;
    logic [MEM_AW-1:0] word_r;
    logic [31:0]       wdata_r;
    logic [31:0]       lo_word_r;
    logic [31:0]       rdata_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;

    logic              accept_s;
    logic [MEM_AW-1:0] word_hi_s;
    logic [31:0]       lo_sel_s, hi_sel_s;
    logic [3:0]        lo_mask_s, hi_mask_s;
    logic [31:0]       lo_wdata_s, hi_wdata_s;
    logic              split_s, illegal_s;
    logic [31:0]       load_data_s;

    assign accept_s    = i_req_valid && (state_r == IDLE);
    assign word_hi_s   = word_r + {{(MEM_AW-1){1'b0}}, 1'b1};
    assign o_req_ready = (state_r == IDLE);
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_err   = rsp_err_r;
    assign o_rdata     = rdata_r;

    lsu_align u_align (
        .we        (we_r),
        .func3     (func3_r),
        .addr_lo   (offs_r),
        .wdata     (wdata_r),
        .lo_word   (lo_sel_s),
        .hi_word   (hi_sel_s),
        .lo_mask   (lo_mask_s),
        .hi_mask   (hi_mask_s),
        .lo_wdata  (lo_wdata_s),
        .hi_wdata  (hi_wdata_s),
        .split     (split_s),
        .illegal   (illegal_s),
        .load_data (load_data_s)
    );

    // In DATA the memory returns the last word read: the high word when split.
    always_comb begin
        lo_sel_s = i_mem_rdata;
        hi_sel_s = 32'h0000_0000;
        if (split_s) begin
            lo_sel_s = lo_word_r;
            hi_sel_s = i_mem_rdata;
        end else begin
            lo_sel_s = i_mem_rdata;
            hi_sel_s = 32'h0000_0000;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = f3_illegal(i_req_we, i_func3) ? DATA : LO;
                end else begin
                    state_s = IDLE;
                end
            end
            LO:      state_s = split_s ? HI : DATA;
            HI:      state_s = DATA;
            DATA:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Memory strobe outputs, all zero outside LO/HI.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = {MEM_AW{1'b0}};
        o_mem_bmask = 4'b0000;
        o_mem_wdata = 32'h0000_0000;
        case (state_r)
            LO: begin
                o_mem_en    = 1'b1;
                o_mem_we    = we_r;
                o_mem_addr  = word_r;
                o_mem_bmask = we_r ? lo_mask_s : 4'b1111;
                o_mem_wdata = we_r ? lo_wdata_s : 32'h0000_0000;
            end
            HI: begin
                o_mem_en    = 1'b1;
                o_mem_we    = we_r;
                o_mem_addr  = word_hi_s;
                o_mem_bmask = hi_mask_s;
                o_mem_wdata = we_r ? hi_wdata_s : 32'h0000_0000;
            end
            default: begin
                o_mem_en    = 1'b0;
                o_mem_we    = 1'b0;
                o_mem_addr  = {MEM_AW{1'b0}};
                o_mem_bmask = 4'b0000;
                o_mem_wdata = 32'h0000_0000;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch, low-word capture and registered response.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            we_r        <= 1'b0;
            func3_r     <= 3'b000;
            offs_r      <= 2'b00;
            word_r      <= {MEM_AW{1'b0}};
            wdata_r     <= 32'h0000_0000;
            lo_word_r   <= 32'h0000_0000;
            rdata_r     <= 32'h0000_0000;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                we_r    <= i_req_we;
                func3_r <= i_func3;
                offs_r  <= i_addr[1:0];
                word_r  <= i_addr[MEM_AW+1:2];
                wdata_r <= i_wdata;
            end
            if ((state_r == HI) && !we_r) begin
                lo_word_r <= i_mem_rdata;
            end
            rsp_valid_r <= (state_r == DATA);
            if (state_r == DATA) begin
                rsp_err_r <= illegal_s;
                if (illegal_s) begin
                    rdata_r <= 32'h0000_0000;
                end else if (!we_r) begin
                    rdata_r <= load_data_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a behavioural word memory.
module tb_lsu_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_func3 = 3'b000;
    logic [15:0] i_addr = 16'h0000;
    logic [31:0] i_wdata = 32'h0;
    logic        o_rsp_valid;
    logic        o_rsp_err;
    logic [31:0] o_rdata;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [8:0]  o_mem_addr;
    logic [3:0]  o_mem_bmask;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata = 32'h0;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:511];
    int          n_strobe = 0;
    logic        s_we    [0:3];
    logic [8:0]  s_addr  [0:3];
    logic [3:0]  s_bmask [0:3];
    logic [31:0] s_wdata [0:3];
    int          lat;
    logic        rsp_err_c;
    logic [31:0] rdata_c;
    logic        any_valid;

    lsu_ctrl #(.MEM_AW(9)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(i_req_valid),
        .o_req_ready(o_req_ready), .i_req_we(i_req_we), .i_func3(i_func3),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_rsp_valid(o_rsp_valid),
        .o_rsp_err(o_rsp_err), .o_rdata(o_rdata), .o_mem_en(o_mem_en),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_bmask(o_mem_bmask),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Byte-masked single-port memory with one-cycle read latency.
    always @(posedge i_clk) begin
        if (o_mem_en && o_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (o_mem_bmask[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
            end
        end
        if (o_mem_en && !o_mem_we) i_mem_rdata <= mem[o_mem_addr];
    end

    // Record each strobe seen mid-cycle.
    always @(negedge i_clk) begin
        if (o_mem_en && n_strobe < 4) begin
            s_we[n_strobe]    = o_mem_we;
            s_addr[n_strobe]  = o_mem_addr;
            s_bmask[n_strobe] = o_mem_bmask;
            s_wdata[n_strobe] = o_mem_wdata;
            n_strobe          = n_strobe + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [15:0] a,
                           input logic [31:0] wd, output int latency);
        @(negedge i_clk);
        n_strobe    = 0;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_func3     = f3;
        i_addr      = a;
        i_wdata     = wd;
        chk("req_ready", {31'b0, o_req_ready}, 32'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        latency = 1;
        while (!o_rsp_valid && latency < 12) begin
            @(negedge i_clk);
            latency++;
        end
        if (!o_rsp_valid) latency = 99;
        rsp_err_c = o_rsp_err;
        rdata_c   = o_rdata;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        chk("rst_ready", {31'b0, o_req_ready}, 32'd1);
        chk("rst_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("rst_err", {31'b0, o_rsp_err}, 32'd0);
        chk("rst_rdata", o_rdata, 32'h0);
        chk("rst_mem", {o_mem_en, o_mem_we, o_mem_addr, o_mem_bmask, o_mem_wdata[16:0]}, 32'h0);

        // SW aligned, then LW back
        run_req(1'b1, 3'b010, 16'h0004, 32'hA1B2C3D4, lat);
        chk("sw_lat", lat, 32'd3);
        chk("sw_err", {31'b0, rsp_err_c}, 32'd0);
        chk("sw_nstrobe", n_strobe, 32'd1);
        chk("sw_s0", {s_we[0], 18'b0, s_addr[0], s_bmask[0]}, {1'b1, 18'b0, 9'd1, 4'b1111});
        chk("sw_s0_wdata", s_wdata[0], 32'hA1B2C3D4);
        chk("sw_rdata_held", rdata_c, 32'h0);
        run_req(1'b0, 3'b010, 16'h0004, 32'h0, lat);
        chk("lw_lat", lat, 32'd3);
        chk("lw_rdata", rdata_c, 32'hA1B2C3D4);
        chk("lw_s0", {s_we[0], 18'b0, s_addr[0], s_bmask[0]}, {1'b0, 18'b0, 9'd1, 4'b1111});

        // SH split across words 1/2
        run_req(1'b1, 3'b001, 16'h0007, 32'h0000BEEF, lat);
        chk("sh_lat", lat, 32'd4);
        chk("sh_nstrobe", n_strobe, 32'd2);
        chk("sh_s0", {19'b0, s_addr[0], s_bmask[0]}, {19'b0, 9'd1, 4'b1000});
        chk("sh_s0_wdata", s_wdata[0], 32'hEF000000);
        chk("sh_s1", {19'b0, s_addr[1], s_bmask[1]}, {19'b0, 9'd2, 4'b0001});
        chk("sh_s1_wdata", s_wdata[1], 32'h000000BE);
        chk("sh_rdata_held", rdata_c, 32'hA1B2C3D4);
        run_req(1'b0, 3'b001, 16'h0007, 32'h0, lat);
        chk("lh_lat", lat, 32'd4);
        chk("lh_rdata", rdata_c, 32'hFFFFBEEF);
        chk("lh_addrs", {s_addr[0], s_addr[1]}, {14'b0, 9'd1, 9'd2});
        run_req(1'b0, 3'b101, 16'h0007, 32'h0, lat);
        chk("lhu_lat", lat, 32'd4);
        chk("lhu_rdata", rdata_c, 32'h0000BEEF);

        // SW wrapping word 511 -> 0
        run_req(1'b1, 3'b010, 16'h07FE, 32'h11223344, lat);
        chk("swwrap_lat", lat, 32'd4);
        chk("swwrap_s0", {19'b0, s_addr[0], s_bmask[0]}, {19'b0, 9'd511, 4'b1100});
        chk("swwrap_s0_wdata", s_wdata[0], 32'h33440000);
        chk("swwrap_s1", {19'b0, s_addr[1], s_bmask[1]}, {19'b0, 9'd0, 4'b0011});
        chk("swwrap_s1_wdata", s_wdata[1], 32'h00001122);
        run_req(1'b0, 3'b010, 16'h07FE, 32'h0, lat);
        chk("lwwrap_rdata", rdata_c, 32'h11223344);

        // Byte loads
        run_req(1'b1, 3'b010, 16'h0004, 32'h80FF0000, lat);
        run_req(1'b0, 3'b000, 16'h0006, 32'h0, lat);
        chk("lb_lat", lat, 32'd3);
        chk("lb_rdata", rdata_c, 32'hFFFFFFFF);
        run_req(1'b0, 3'b100, 16'h0007, 32'h0, lat);
        chk("lbu_rdata", rdata_c, 32'h00000080);

        // Illegal func3
        run_req(1'b0, 3'b011, 16'h0004, 32'h0, lat);
        chk("ill_lat", lat, 32'd2);
        chk("ill_err", {31'b0, rsp_err_c}, 32'd1);
        chk("ill_rdata", rdata_c, 32'h0);
        chk("ill_nstrobe", n_strobe, 32'd0);
        run_req(1'b0, 3'b100, 16'h0004, 32'h0, lat);
        run_req(1'b1, 3'b100, 16'h0004, 32'h55, lat);
        chk("ill_st_err", {31'b0, rsp_err_c}, 32'd1);
        chk("ill_st_rdata", rdata_c, 32'h0);
        run_req(1'b0, 3'b000, 16'h0007, 32'h0, lat);
        chk("post_ill_err", {31'b0, rsp_err_c}, 32'd0);
        chk("post_ill_rdata", rdata_c, 32'hFFFFFF80);

        // Reset after the LO strobe of a split store
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_func3     = 3'b010;
        i_addr      = 16'h0102;
        i_wdata     = 32'hCAFEF00D;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("rs_lo", {18'b0, o_mem_en, o_mem_addr, o_mem_bmask}, {18'b0, 1'b1, 9'd64, 4'b1100});
        chk("rs_lo_wdata", o_mem_wdata, 32'hF00D0000);
        i_reset = 1'b0;
        @(negedge i_clk);
        n_strobe = 0;
        chk("rs_ready", {31'b0, o_req_ready}, 32'd1);
        chk("rs_outs", {o_rsp_valid, o_rsp_err, o_mem_en, o_mem_we, o_mem_addr, o_mem_bmask}, 32'h0);
        chk("rs_wdata", o_mem_wdata, 32'h0);
        chk("rs_rdata", o_rdata, 32'h0);
        i_reset = 1'b1;
        any_valid = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            any_valid = any_valid | o_rsp_valid;
        end
        chk("rs_no_rsp", {31'b0, any_valid}, 32'd0);
        chk("rs_no_strobe", n_strobe, 32'd0);
        chk("rs_mem_lo", mem[64], 32'hF00D0000);
        chk("rs_mem_hi", mem[65], 32'h0);
        run_req(1'b0, 3'b010, 16'h0102, 32'h0, lat);
        chk("rs_lw_lat", lat, 32'd4);
        chk("rs_lw_rdata", rdata_c, 32'h0000F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
